// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU top level and its program loader.
//   loader_state_e    : program loader FSM states
//   RAM_BYTES_DEFAULT : default program RAM size in bytes
//   sum8              : 8-bit modular add used by the loader checksum
package cpu_pkg;

  localparam int RAM_BYTES_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_WAIT_STB = 3'd1,
    ST_WRITE    = 3'd2,
    ST_CHECK    = 3'd3,
    ST_WAIT_REL = 3'd4,
    ST_RUN      = 3'd5,
    ST_ERR      = 3'd6
  } loader_state_e;

  // Carry is discarded on purpose: the checksum is the sum modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for an asynchronous input pin, plus edge detect.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, all flops clear to 0
//   pin   : asynchronous input
//   rise  : one-cycle pulse when the synchronized level goes 0 -> 1
//   fall  : one-cycle pulse when the synchronized level goes 1 -> 0
// Because every flop resets to 0, a pin already high at reset release
// is reported as a single rise once it has crossed the synchronizer.
module pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader for the CPU's program RAM.
//   clk, rst_n          : clock and asynchronous active-low reset
//   load_en             : sampled once after reset; 1 = load, 0 = run at once
//   stb, din            : host strobe (asynchronous) and data byte
//   ack                 : byte accepted, held until the host drops stb
//   ram_addr/data/we    : RAM write port, we is a one-cycle pulse
//   cpu_rst_n           : CPU core reset, released only once in RUN
//   busy, err           : load in progress / sticky checksum mismatch
//   dbg_state           : current loader state, for observation only
//
// Handshake (4-phase): host drives din, raises stb; the loader captures
// din on the synchronized rise, writes it, raises ack; the host drops
// stb; the loader drops ack on the synchronized fall. RAM_BYTES data
// bytes are followed by one checksum byte equal to their sum mod 256.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int RAM_BYTES = RAM_BYTES_DEFAULT,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              stb,
  input  logic [7:0]        din,
  output logic              ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err,
  output loader_state_e     dbg_state
);

  // One extra counter bit so reaching RAM_BYTES does not wrap to 0.
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(RAM_BYTES);

  loader_state_e     state, state_n;
  loader_state_e     pend, pend_n;     // where WAIT_REL goes once stb drops
  logic [ADDR_W:0]   cnt, cnt_n;
  logic [7:0]        sum, sum_n;
  logic [7:0]        chk, chk_n;       // received checksum byte
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;
  logic              err_n;
  logic              stb_rise, stb_fall;

  pin_sync u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (stb),
    .rise  (stb_rise),
    .fall  (stb_fall)
  );

  always_comb begin
    state_n = state;
    pend_n  = pend;
    cnt_n   = cnt;
    sum_n   = sum;
    chk_n   = chk;
    addr_n  = ram_addr;
    data_n  = ram_data;
    err_n   = err;
    case (state)
      ST_INIT: begin
        state_n = load_en ? ST_WAIT_STB : ST_RUN;
      end
      ST_WAIT_STB: begin
        if (stb_rise) begin
          if (cnt < CNT_FULL) begin
            addr_n  = cnt[ADDR_W-1:0];
            data_n  = din;
            sum_n   = sum8(sum, din);
            state_n = ST_WRITE;
          end else begin
            chk_n   = din;
            state_n = ST_CHECK;
          end
        end
      end
      ST_WRITE: begin
        cnt_n   = cnt + 1'b1;
        pend_n  = ST_WAIT_STB;
        state_n = ST_WAIT_REL;
      end
      ST_CHECK: begin
        if (chk == sum) begin
          pend_n = ST_RUN;
        end else begin
          pend_n = ST_ERR;
          err_n  = 1'b1;
        end
        state_n = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        // A strobe that dropped before ack rose leaves WAIT_REL waiting
        // for the next fall the synchronizer reports.
        if (stb_fall) state_n = pend;
      end
      ST_RUN: begin
        state_n = ST_RUN;
      end
      ST_ERR: begin
        err_n   = 1'b1;
        state_n = ST_ERR;
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  // Outputs are registered so the pins and the CPU reset never glitch.
  // ack/ram_we/busy follow the state being entered; cpu_rst_n follows
  // the state already reached, releasing the CPU one cycle into RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      pend      <= ST_WAIT_STB;
      cnt       <= '0;
      sum       <= 8'h00;
      chk       <= 8'h00;
      ram_addr  <= '0;
      ram_data  <= 8'h00;
      ram_we    <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      cnt       <= cnt_n;
      sum       <= sum_n;
      chk       <= chk_n;
      ram_addr  <= addr_n;
      ram_data  <= data_n;
      ram_we    <= (state_n == ST_WRITE);
      ack       <= (state_n == ST_WRITE) || (state_n == ST_CHECK) ||
                   (state_n == ST_WAIT_REL);
      busy      <= (state_n == ST_WAIT_STB) || (state_n == ST_WRITE) ||
                   (state_n == ST_CHECK) || (state_n == ST_WAIT_REL);
      err       <= err_n;
      cpu_rst_n <= (state == ST_RUN);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a driver performs the 4-phase
// strobe/ack handshake, expected RAM writes go into exp_q, and a monitor
// pops and compares on every ram_we pulse while keeping a RAM image.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int RAM_BYTES = 16;
  localparam int ADDR_W    = 4;
  localparam int W         = ADDR_W + 8;

  typedef logic [7:0] prog_t [RAM_BYTES];

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_en = 1'b0;
  logic              stb = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cpu_rst_n;
  logic              busy;
  logic              err;
  loader_state_e     dbg_state;

  always #5 clk = ~clk;

  prog_loader #(.RAM_BYTES(RAM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .stb       (stb),
    .din       (din),
    .ack       (ack),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] ram_img [RAM_BYTES];
  int         we_cnt = 0;
  int         ack_rises = 0;
  logic       prev_we = 1'b0;
  logic       prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no DUT response within the cycle budget", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_checksum(input prog_t p);
    int s = 0;
    for (int i = 0; i < RAM_BYTES; i++) s += p[i];
    return 8'(s % 256);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we  = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (ram_we) begin
        check("ram_we_single_cycle", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write",
                   ram_addr, ram_data);
        end else begin
          check("ram_write", {20'd0, ram_addr, ram_data}, {20'd0, exp_q.pop_front()});
        end
        ram_img[ram_addr] = ram_data;
        we_cnt++;
      end
      if (ack && !prev_ack) ack_rises++;
      prev_we  = ram_we;
      prev_ack = ack;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic le, input logic stb_level, input logic [7:0] d);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    load_en = le;
    stb     = stb_level;
    din     = d;
    @(negedge clk);
    check("reset_outputs", {25'd0, ack, ram_addr != 0, ram_data != 0, ram_we,
                            cpu_rst_n, busy, err}, 32'd0);
    check("writes_outstanding_at_reset", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen;
    @(posedge clk);
    #2;
    din = b;
    stb = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack) begin seen = 1; break; end
    end
    if (!seen) fail_now("ack_rise");
    @(posedge clk);
    #2;
    stb = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!ack) begin seen = 1; break; end
    end
    if (!seen) fail_now("ack_fall");
  endtask

  task automatic load_prog(input prog_t p, input logic [7:0] cks);
    for (int i = 0; i < RAM_BYTES; i++) begin
      exp_q.push_back({ADDR_W'(i), p[i]});
      send_byte(p[i]);
    end
    send_byte(cks);
  endtask

  task automatic check_end(input logic good);
    repeat (3) @(negedge clk);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_err", {31'd0, err}, {31'd0, !good});
    check("end_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, good});
  endtask

  task automatic check_image(input prog_t p);
    for (int i = 0; i < RAM_BYTES; i++)
      check($sformatf("ram_img[%0d]", i), {24'd0, ram_img[i]}, {24'd0, p[i]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    prog_t p, p2;
    int    base, lat;
    logic  good;
    logic [7:0] cks;

    repeat (2) @(posedge clk);

    // load_en=0: run immediately, no writes.
    base = we_cnt;
    do_reset(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("skip_cpu_rst_n_cycle1", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    check("skip_cpu_rst_n_cycle2", {31'd0, cpu_rst_n}, 32'd1);
    check("skip_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("skip_no_writes", we_cnt - base, 0);

    // Directed program with correct checksum.
    for (int i = 0; i < RAM_BYTES; i++) p[i] = 8'((16 * i + i) % 256);
    do_reset(1'b1, 1'b0, 8'h00);
    base = ack_rises;
    load_prog(p, model_checksum(p));
    repeat (3) @(negedge clk);
    check("directed_ack_count", ack_rises - base, RAM_BYTES + 1);
    check_end(1'b1);
    check_image(p);

    // Same program, wrong checksum, then a strobe that must be ignored.
    do_reset(1'b1, 1'b0, 8'h00);
    load_prog(p, 8'h00);
    check_end(1'b0);
    base = ack_rises;
    @(posedge clk);
    #2;
    din = 8'h55;
    stb = 1'b1;
    repeat (12) @(negedge clk);
    check("err_strobe_no_ack", ack_rises - base, 0);
    check("err_state_hold", {29'd0, dbg_state}, {29'd0, ST_ERR});
    stb = 1'b0;

    // Latency of one byte.
    do_reset(1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("busy_while_waiting", {31'd0, busy}, 32'd1);
    exp_q.push_back({ADDR_W'(0), 8'hA5});
    @(posedge clk);
    #2;
    din = 8'hA5;
    stb = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_we) begin lat = k; break; end
    end
    check("we_latency_negedges", lat, 4);
    check("ack_with_we", {31'd0, ack}, 32'd1);
    @(negedge clk);
    check("we_drops", {31'd0, ram_we}, 32'd0);
    repeat (4) @(negedge clk);
    check("ack_held_while_stb", {31'd0, ack}, 32'd1);
    @(posedge clk);
    #2;
    stb = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!ack) begin lat = k; break; end
    end
    check("ack_fall_latency_negedges", lat, 4);

    // Reset after 5 bytes, then a full reload.
    do_reset(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      p[i] = 8'($urandom_range(0, 255));
      exp_q.push_back({ADDR_W'(i), p[i]});
      send_byte(p[i]);
    end
    do_reset(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < RAM_BYTES; i++) p2[i] = 8'($urandom_range(0, 255));
    load_prog(p2, model_checksum(p2));
    check_end(1'b1);
    check_image(p2);

    // Random programs with random good/bad checksums.
    for (int n = 0; n < 3; n++) begin
      do_reset(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < RAM_BYTES; i++) p[i] = 8'($urandom);
      good = 1'($urandom_range(0, 1));
      cks  = model_checksum(p);
      if (!good) cks = cks ^ 8'($urandom_range(1, 255));
      load_prog(p, cks);
      check_end(good);
      check_image(p);
    end

    // stb already high across reset release: exactly one byte at addr 0.
    do_reset(1'b1, 1'b1, 8'h3C);
    base = we_cnt;
    exp_q.push_back({ADDR_W'(0), 8'h3C});
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack) begin lat = 1; break; end
    end
    if (lat == 0) fail_now("held_stb_ack_rise");
    @(posedge clk);
    #2;
    stb = 1'b0;
    repeat (8) @(negedge clk);
    check("held_stb_write_count", we_cnt - base, 1);
    check("held_stb_queue_empty", exp_q.size(), 0);
    check("held_stb_ack_low", {31'd0, ack}, 32'd0);
    check("held_stb_state", {29'd0, dbg_state}, {29'd0, ST_WAIT_STB});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #2000000;
    fail_now("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
